// File: rtl/x_xor_parity_pipe.sv
// x_xor_parity_pipe
// Reduces a WIDTH-bit word to a single parity bit through a tree of
// 4-input XOR levels. The tree is either registered after every level
// (PIPE=1) or fully combinational in front of a single register (PIPE=0).
// An output stage can also fold several words into one frame parity.
// IV, ILAST and IACC travel through the pipeline together with their word.

module x_xor_parity_pipe #(
  parameter int WIDTH   = 32,
  parameter int PIPE    = 1,
  parameter int INV_OUT = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  input  logic             IV,
  input  logic             ILAST,
  input  logic             IACC,
  output logic             O,
  output logic             OV,
  output logic             OLAST
);

  // Returns the number of 4:1 reduction levels needed to reach one bit.
  // Even WIDTH=1 gets one level, so the pipeline shape never degenerates.
  function automatic int tree_levels(input int w);
    int n;
    int rem;
    n   = 0;
    rem = w;
    while (rem > 1) begin
      rem = (rem + 3) / 4;
      n   = n + 1;
    end
    if (n < 1) begin
      n = 1;
    end else begin
      n = n;
    end
    return n;
  endfunction

  // Applies one tree level: output bit g is the XOR of input bits 4g..4g+3.
  // Bits above the current level width are always zero. That zero-pads the
  // short final group and keeps the upper part of the result at zero.
  function automatic logic [WIDTH-1:0] xor4_level(input logic [WIDTH-1:0] v);
    logic [4*WIDTH-1:0] pad;
    logic [WIDTH-1:0]   r;
    pad = {{(3*WIDTH){1'b0}}, v};
    r   = '0;
    for (int g = 0; g < WIDTH; g++) begin
      r[g] = ^pad[4*g +: 4];
    end
    return r;
  endfunction

  localparam int   LEVELS  = tree_levels(WIDTH);
  localparam int   NSTAGE  = (PIPE != 0) ? LEVELS : 1;
  localparam logic INV_BIT = (INV_OUT != 0) ? 1'b1 : 1'b0;

  // Tree data registers plus the sideband that travels with each word.
  logic [WIDTH-1:0]  tree_d [NSTAGE];
  logic [WIDTH-1:0]  tree_q [NSTAGE];
  logic [NSTAGE-1:0] v_d;
  logic [NSTAGE-1:0] v_q;
  logic [NSTAGE-1:0] last_d;
  logic [NSTAGE-1:0] last_q;
  logic [NSTAGE-1:0] acc_d;
  logic [NSTAGE-1:0] acc_q;

  // Output stage: running frame parity and the registered outputs.
  logic r_d;
  logic r_q;
  logic o_d;
  logic o_q;
  logic ov_d;
  logic ov_q;
  logic olast_d;
  logic olast_q;

  // Parity of the word that has reached the output stage.
  logic word_par_s;

  // Next state of the tree. PIPE=1 advances one level per register.
  // PIPE=0 collapses every level into the first register.
  always_comb begin
    logic [WIDTH-1:0] flat;
    flat = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      tree_d[k] = '0;
    end
    if (PIPE != 0) begin
      tree_d[0] = xor4_level(I);
      for (int k = 1; k < NSTAGE; k++) begin
        tree_d[k] = xor4_level(tree_q[k-1]);
      end
    end else begin
      flat = I;
      for (int k = 0; k < LEVELS; k++) begin
        flat = xor4_level(flat);
      end
      tree_d[0] = flat;
    end
  end

  // Sideband shift chain, kept in lockstep with the tree data.
  always_comb begin
    v_d[0]    = IV;
    last_d[0] = ILAST;
    acc_d[0]  = IACC;
    for (int k = 1; k < NSTAGE; k++) begin
      v_d[k]    = v_q[k-1];
      last_d[k] = last_q[k-1];
      acc_d[k]  = acc_q[k-1];
    end
  end

  // Only bit 0 of the final level can be nonzero, so its full reduction is the word parity.
  assign word_par_s = ^tree_q[NSTAGE-1];

  // Output stage. Standalone words leave R alone. Frame words fold into R.
  // The frame's last word emits R^p and clears R in the same cycle.
  always_comb begin
    r_d     = r_q;
    o_d     = o_q;
    ov_d    = 1'b0;
    olast_d = olast_q;
    if (v_q[NSTAGE-1]) begin
      if (!acc_q[NSTAGE-1]) begin
        o_d     = word_par_s ^ INV_BIT;
        ov_d    = 1'b1;
        olast_d = 1'b1;
      end else if (!last_q[NSTAGE-1]) begin
        r_d = r_q ^ word_par_s;
      end else begin
        o_d     = r_q ^ word_par_s ^ INV_BIT;
        ov_d    = 1'b1;
        olast_d = 1'b1;
        r_d     = 1'b0;
      end
    end else begin
      ov_d = 1'b0;
    end
  end

  // All state registers. An async reset drops in-flight words and any open frame.
  // CE low freezes everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NSTAGE; k++) begin
        tree_q[k] <= '0;
      end
      v_q     <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      r_q     <= 1'b0;
      o_q     <= 1'b0;
      ov_q    <= 1'b0;
      olast_q <= 1'b0;
    end else if (CE) begin
      for (int k = 0; k < NSTAGE; k++) begin
        tree_q[k] <= tree_d[k];
      end
      v_q     <= v_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
      olast_q <= olast_d;
    end
  end

  assign O     = o_q;
  assign OV    = ov_q;
  assign OLAST = olast_q;

endmodule

// File: tb/tb_x_xor_parity_pipe.sv
// Testbench for x_xor_parity_pipe.
// Two instances share one stimulus stream:
//   A: WIDTH=32, PIPE=1, INV_OUT=0, latency 4
//   B: WIDTH=5,  PIPE=0, INV_OUT=1, latency 2, driven from din[4:0]
// The reference model computes each word's result when the word is accepted.
// That result is scheduled for the enabled cycle on which it must appear.

module tb_x_xor_parity_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        iv;
  logic        ilast;
  logic        iacc;
  logic [31:0] din;
  logic        o_a, ov_a, olast_a;
  logic        o_b, ov_b, olast_b;

  // Free-running clock.
  always #5 clk = ~clk;

  x_xor_parity_pipe #(.WIDTH(32), .PIPE(1), .INV_OUT(0)) dut_a (
    .CLK(clk), .RST(rst), .CE(ce), .I(din), .IV(iv), .ILAST(ilast), .IACC(iacc),
    .O(o_a), .OV(ov_a), .OLAST(olast_a)
  );

  x_xor_parity_pipe #(.WIDTH(5), .PIPE(0), .INV_OUT(1)) dut_b (
    .CLK(clk), .RST(rst), .CE(ce), .I(din[4:0]), .IV(iv), .ILAST(ilast), .IACC(iacc),
    .O(o_b), .OV(ov_b), .OLAST(olast_b)
  );

  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state, one slot per instance.
  int   lat [2] = '{4, 2};
  logic inv_m [2] = '{1'b0, 1'b1};
  logic rm [2];
  logic sv [2][8];
  logic so [2][8];
  logic eo [2];
  logic eov [2];
  logic eol [2];
  bit   known [2];
  bit   stall_now;
  int   ecnt;

  function automatic logic wpar(input int d, input logic [31:0] w);
    logic [4:0] lo;
    lo = w[4:0];
    return (d == 0) ? ^w : ^lo;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      rm[d] = 1'b0; eo[d] = 1'b0; eov[d] = 1'b0; eol[d] = 1'b0; known[d] = 1'b1;
      for (int s = 0; s < 8; s++) begin
        sv[d][s] = 1'b0; so[d][s] = 1'b0;
      end
    end
    ecnt = 0;
    stall_now = 1'b0;
  endtask

  task automatic schedule(input int d, input logic val);
    int s;
    s = (ecnt + lat[d] - 1) % 8;
    sv[d][s] = 1'b1;
    so[d][s] = val;
  endtask

  // Advance the model by one clock edge, using the inputs sampled at that edge.
  task automatic model_edge();
    logic p;
    int   slot;
    if (rst) begin
      model_reset();
    end else if (!ce) begin
      stall_now = 1'b1;
    end else begin
      stall_now = 1'b0;
      slot = ecnt % 8;
      for (int d = 0; d < 2; d++) begin
        if (sv[d][slot]) begin
          eo[d] = so[d][slot]; eov[d] = 1'b1; eol[d] = 1'b1; known[d] = 1'b1;
          sv[d][slot] = 1'b0;
        end else begin
          eov[d] = 1'b0; known[d] = 1'b0;
        end
        if (iv) begin
          p = wpar(d, din);
          if (!iacc) begin
            schedule(d, p ^ inv_m[d]);
          end else if (!ilast) begin
            rm[d] = rm[d] ^ p;
          end else begin
            schedule(d, rm[d] ^ p ^ inv_m[d]);
            rm[d] = 1'b0;
          end
        end
      end
      ecnt++;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ov_a", ov_a, eov[0]);
    if (eov[0] || rst || (stall_now && known[0])) begin
      chk("o_a", o_a, eo[0]);
      chk("olast_a", olast_a, eol[0]);
    end
    chk("ov_b", ov_b, eov[1]);
    if (eov[1] || rst || (stall_now && known[1])) begin
      chk("o_b", o_b, eo[1]);
      chk("olast_b", olast_b, eol[1]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic put(input logic [31:0] w, input logic v_in, input logic l_in, input logic a_in);
    din = w; iv = v_in; ilast = l_in; iacc = a_in;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      put($urandom, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1; iv = 1'b0; ilast = 1'b0; iacc = 1'b0; din = 32'h0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset asserted between edges clears outputs at once, then holds for 3 cycles.
    din = $urandom; iv = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int k = 0; k < 3; k++) begin
      put($urandom, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    iv  = 1'b0;

    // Standalone words on consecutive cycles.
    put(32'h0000_0001, 1'b1, 1'b0, 1'b0);
    put(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    put(32'h8000_0003, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Three-word frame.
    put(32'h1, 1'b1, 1'b0, 1'b1);
    put(32'h3, 1'b1, 1'b0, 1'b1);
    put(32'h7, 1'b1, 1'b1, 1'b1);
    idle(6);

    // Frame with bubbles inside.
    put(32'h5, 1'b1, 1'b0, 1'b1);
    idle(2);
    put(32'h1, 1'b1, 1'b0, 1'b1);
    idle(1);
    put(32'h2, 1'b1, 1'b1, 1'b1);
    idle(6);

    // Back-to-back frames with a standalone word between them.
    put(32'h1, 1'b1, 1'b1, 1'b1);
    put(32'hF, 1'b1, 1'b0, 1'b0);
    put(32'h3, 1'b1, 1'b0, 1'b1);
    put(32'h1, 1'b1, 1'b1, 1'b1);
    idle(6);

    // CE low for 2 cycles, one cycle after a word. Inputs during the stall are ignored.
    put(32'h1, 1'b1, 1'b0, 1'b0);
    idle(1);
    ce = 1'b0;
    put($urandom, 1'b1, 1'b1, 1'b0);
    put($urandom, 1'b1, 1'b1, 1'b0);
    ce = 1'b1;
    idle(6);

    // Stall right after an output event, so the held values are known.
    put(32'h1, 1'b1, 1'b0, 1'b0);
    idle(3);
    ce = 1'b0;
    put($urandom, 1'b1, 1'b0, 1'b0);
    put($urandom, 1'b1, 1'b0, 1'b0);
    ce = 1'b1;
    idle(4);

    // Async reset pulse between edges, with a frame open and words in flight.
    put(32'h1, 1'b1, 1'b0, 1'b1);
    put(32'h3, 1'b1, 1'b0, 1'b1);
    iv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
    put(32'h1, 1'b1, 1'b1, 1'b1);
    idle(6);

    // Unknown bit in one standalone word affects that word's result only.
    put({31'h0, 1'bx}, 1'b1, 1'b0, 1'b0);
    put(32'h3, 1'b1, 1'b0, 1'b0);
    idle(6);

    // All-zero word: instance B has an inverted output, so O=1 there.
    put(32'h0, 1'b1, 1'b0, 1'b0);
    idle(5);

    // Random traffic with occasional CE stalls.
    for (int k = 0; k < 400; k++) begin
      ce = ($urandom_range(0, 9) != 0);
      put($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)));
    end
    ce = 1'b1;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
